axi4_lite_slv_regs: RTL and testbench
=====================================

// Module: axi4_lite_slv_regs
// PURPOSE
// AXI4-Lite slave register bank on the slave side of the axi4_lite_if bus.
// Holds P_NUM_REGS word-wide read/write registers addressed by word offset; it is the
// reference DUT and endpoint for the master driver.
// Write and read channels run independently; one outstanding transaction per direction.
// PARAMETERS
// P_DATA_WIDTH  32  data bus width in bits (multiple of 8; wstrb is P_DATA_WIDTH/8 bits)
// P_ADDR_WIDTH  32  address bus width in bits
// P_NUM_REGS    16  number of registers; reg i sits at byte address i*(P_DATA_WIDTH/8)
// PORTS
// clk      in   1               clock, all logic on rising edge
// arst_n   in   1               reset, synchronous, active-low
// awvalid  in   1               write address valid
// awready  out  1               write address ready
// awaddr   in   P_ADDR_WIDTH    write byte address
// awprot   in   3               write protection (ignored)
// wvalid   in   1               write data valid
// wready   out  1               write data ready
// wdata    in   P_DATA_WIDTH    write data
// wstrb    in   P_DATA_WIDTH/8  byte-lane write strobes
// bvalid   out  1               write response valid
// bready   in   1               write response ready
// bresp    out  3               write response: 3'b000 OKAY, 3'b010 SLVERR
// arvalid  in   1               read address valid
// arready  out  1               read address ready
// araddr   in   P_ADDR_WIDTH    read byte address
// arprot   in   3               read protection (ignored)
// rvalid   out  1               read data valid
// rready   in   1               read data ready
// rdata    out  P_DATA_WIDTH    read data
// rresp    out  3               read response: 3'b000 OKAY, 3'b010 SLVERR
// BEHAVIOUR
// - Reset (arst_n low at clk edge): all registers 0; all outputs 0 (incl. readies).
//   Readies go 1 on first edge with arst_n high; reset mid-transaction drops it with no response.
// - Index = addr >> log2(P_DATA_WIDTH/8); low byte-offset bits ignored.
//   Index >= P_NUM_REGS is out of range.
// - AW/W: each captured independently in a holding reg on valid&&ready.
//   awready=0 while AW held or bvalid=1; wready=0 while W held or bvalid=1.
//   AW and W in same cycle are legal; either order is legal.
// - Once both held (at that edge or later): next edge commits the write and sets bvalid=1.
//   Commit writes each byte lane whose wstrb bit is 1; clears holding regs.
//   Write response is 1 cycle after the later handshake.
// - Out-of-range write: no register changes, bresp=SLVERR; else OKAY.
// - bvalid/bresp stable until bvalid&&bready; bvalid falls that edge; readies return next cycle.
// - Read: arready = !rvalid (registered). On arvalid&&arready, next edge sets rvalid=1.
//   rdata=reg[index], rresp=OKAY; out of range rdata=0, rresp=SLVERR.
//   Held stable until rvalid&&rready.
// - Read and write commit at same edge to same reg: read returns the pre-write value.
// - bresp[2] and rresp[2] always 0. arprot/awprot have no effect.
// TESTING
// - Reset then write 0xDEADBEEF @0x4, wstrb=4'hF -> bvalid 1 cycle after AW/W, bresp=0.
//   Read @0x4 -> rdata=0xDEADBEEF, rresp=0.
// - W two cycles before AW -> wready low until commit; single bvalid; data written correctly.
// - Reg 2 holds 0x11223344; write 0xAABBCCDD wstrb=4'b0101 -> read 0x11BB33DD.
// - Write/read @0x40 (P_NUM_REGS=16) -> bresp=3'b010, rdata=0, rresp=3'b010; regs unchanged.
// - Hold bready=0 for 5 cycles -> bvalid/bresp stable, awready=wready=0 throughout.
//   Same for rready=0 with rvalid/rdata.
// - Pull arst_n low mid-write -> all outputs 0 next edge, all regs read back 0 after release.

Source files
------------

// File: rtl/axi4_lite_slv_regs_if.sv
// ---------------------------------------------------------------------------
// axi4_lite_slv_regs_if
// Bus bundle for an AXI4-Lite link between one master and one slave.
//
// Parameters
//   P_DATA_WIDTH : data width in bits (wstrb carries P_DATA_WIDTH/8 lanes)
//   P_ADDR_WIDTH : byte address width in bits
//
// Modports
//   master : drives AW/W/AR valids and payloads, bready, rready
//   slave  : drives AW/W/AR readies, B and R channel valids and payloads
// ---------------------------------------------------------------------------
interface axi4_lite_slv_regs_if #(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_ADDR_WIDTH = 32
);

  // write address channel
  logic                      awvalid;
  logic                      awready;
  logic [P_ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]                awprot;
  // write data channel
  logic                      wvalid;
  logic                      wready;
  logic [P_DATA_WIDTH-1:0]   wdata;
  logic [P_DATA_WIDTH/8-1:0] wstrb;
  // write response channel
  logic                      bvalid;
  logic                      bready;
  logic [2:0]                bresp;
  // read address channel
  logic                      arvalid;
  logic                      arready;
  logic [P_ADDR_WIDTH-1:0]   araddr;
  logic [2:0]                arprot;
  // read data channel
  logic                      rvalid;
  logic                      rready;
  logic [P_DATA_WIDTH-1:0]   rdata;
  logic [2:0]                rresp;

  modport master (
    output awvalid, awaddr, awprot,
    output wvalid, wdata, wstrb,
    output bready,
    output arvalid, araddr, arprot,
    output rready,
    input  awready, wready,
    input  bvalid, bresp,
    input  arready,
    input  rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    input  wvalid, wdata, wstrb,
    input  bready,
    input  arvalid, araddr, arprot,
    input  rready,
    output awready, wready,
    output bvalid, bresp,
    output arready,
    output rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi4_lite_slv_regs.sv
// ---------------------------------------------------------------------------
// axi4_lite_slv_regs
// AXI4-Lite slave holding P_NUM_REGS word-wide read/write registers.
// Register i lives at byte address i*(P_DATA_WIDTH/8); byte-offset bits of
// the address are ignored. Word indices >= P_NUM_REGS answer SLVERR (writes
// are dropped, reads return 0). Write and read sides run independently with
// at most one transaction in flight on each.
//
// Ports
//   clk    : clock, everything on the rising edge
//   arst_n : reset, synchronous, active-low; clears registers and outputs
//   s_axi  : AXI4-Lite slave modport (AW, W, B, AR, R channels)
// ---------------------------------------------------------------------------
module axi4_lite_slv_regs #(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_ADDR_WIDTH = 32,
  parameter int P_NUM_REGS   = 16
) (
  input  logic                 clk,
  input  logic                 arst_n,
  axi4_lite_slv_regs_if.slave  s_axi
);

  localparam int NB     = P_DATA_WIDTH / 8;
  localparam int OFFS_W = (NB > 1) ? $clog2(NB) : 0;
  localparam int IDX_W  = (P_NUM_REGS > 1) ? $clog2(P_NUM_REGS) : 1;

  localparam logic [2:0] RESP_OKAY   = 3'b000;
  localparam logic [2:0] RESP_SLVERR = 3'b010;

  // register file
  logic [P_DATA_WIDTH-1:0] regs_q [P_NUM_REGS];
  logic [P_NUM_REGS-1:0]   reg_we;

  // write side holding registers
  logic                    aw_held_q, aw_held_d;
  logic [IDX_W-1:0]        aw_idx_q, aw_idx_d;
  logic                    aw_oor_q, aw_oor_d;
  logic                    w_held_q, w_held_d;
  logic [P_DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [NB-1:0]           w_strb_q, w_strb_d;
  logic                    bvalid_q, bvalid_d;
  logic [2:0]              bresp_q, bresp_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;

  // read side
  logic                    rvalid_q, rvalid_d;
  logic [P_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [2:0]              rresp_q, rresp_d;
  logic                    arready_q, arready_d;

  // decoded addresses
  logic [P_ADDR_WIDTH-1:0] aw_word;
  logic [P_ADDR_WIDTH-1:0] ar_word;
  logic                    aw_oor;
  logic                    ar_oor;
  logic [IDX_W-1:0]        ar_idx;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic wr_commit;

  // protection bits carry no meaning for this register bank
  logic unused_prot;
  assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

  assign aw_word = s_axi.awaddr >> OFFS_W;
  assign ar_word = s_axi.araddr >> OFFS_W;
  // full-width compare so high address bits can never alias onto a register
  assign aw_oor  = (aw_word >= P_ADDR_WIDTH'(P_NUM_REGS));
  assign ar_oor  = (ar_word >= P_ADDR_WIDTH'(P_NUM_REGS));
  assign ar_idx  = ar_word[IDX_W-1:0];

  assign aw_hs = s_axi.awvalid && awready_q;
  assign w_hs  = s_axi.wvalid  && wready_q;
  assign b_hs  = bvalid_q      && s_axi.bready;
  assign ar_hs = s_axi.arvalid && arready_q;
  assign r_hs  = rvalid_q      && s_axi.rready;

  // Both halves already held at the start of this cycle: this edge commits.
  // Readies are low while anything is held, so nothing new can be captured
  // on the commit edge.
  assign wr_commit = aw_held_q && w_held_q;

  for (genvar gi = 0; gi < P_NUM_REGS; gi++) begin : g_we
    assign reg_we[gi] = wr_commit && !aw_oor_q && (aw_idx_q == IDX_W'(gi));
  end

  // ------------------------------------------------------------------
  // next-state logic for both channels
  // ------------------------------------------------------------------
  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    aw_oor_d  = aw_oor_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = aw_word[IDX_W-1:0];
      aw_oor_d  = aw_oor;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = s_axi.wdata;
      w_strb_d = s_axi.wstrb;
    end

    if (wr_commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = aw_oor_q ? RESP_SLVERR : RESP_OKAY;
    end else if (b_hs) begin
      bvalid_d = 1'b0;
      bresp_d  = RESP_OKAY;
    end

    // Read data is sampled from the registers before any same-edge write
    // lands, so a colliding read sees the old value.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = ar_oor ? '0 : regs_q[ar_idx];
      rresp_d  = ar_oor ? RESP_SLVERR : RESP_OKAY;
    end else if (r_hs) begin
      rvalid_d = 1'b0;
      rdata_d  = '0;
      rresp_d  = RESP_OKAY;
    end

    // Readies are registered from the next state, so they drop on the very
    // edge that captures a beat and rise on the edge that retires a response.
    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d  && !bvalid_d;
    arready_d = !rvalid_d;
  end

  // ------------------------------------------------------------------
  // state registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      aw_oor_q  <= 1'b0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      aw_oor_q  <= aw_oor_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      arready_q <= arready_d;
    end
  end

  // register file with per-byte-lane write enables
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      for (int r = 0; r < P_NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < P_NUM_REGS; r++) begin
        for (int b = 0; b < NB; b++) begin
          if (reg_we[r] && w_strb_q[b]) begin
            regs_q[r][8*b +: 8] <= w_data_q[8*b +: 8];
          end
        end
      end
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

endmodule

// File: tb/tb_axi4_lite_slv_regs.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_slv_regs
// Directed and randomized checks of the AXI4-Lite register bank against a
// simple array model of the register contents.
// ---------------------------------------------------------------------------
module tb_axi4_lite_slv_regs;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 16;
  localparam logic [2:0] OKAY   = 3'b000;
  localparam logic [2:0] SLVERR = 3'b010;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_lite_slv_regs_if #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) bus ();

  axi4_lite_slv_regs #(
    .P_DATA_WIDTH(DW),
    .P_ADDR_WIDTH(AW),
    .P_NUM_REGS  (NR)
  ) dut (
    .clk   (clk),
    .arst_n(arst_n),
    .s_axi (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [NR];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int unsigned idx;
    idx = addr >> 2;
    return (idx < NR) ? model[idx] : 32'h0;
  endfunction

  function automatic logic [2:0] model_resp(input logic [31:0] addr);
    int unsigned idx;
    idx = addr >> 2;
    return (idx < NR) ? OKAY : SLVERR;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
    int unsigned idx;
    idx = addr >> 2;
    if (idx < NR) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
      end
    end
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_awready"}, 32'(bus.awready), 32'd0);
    check({tag, "_wready"},  32'(bus.wready),  32'd0);
    check({tag, "_arready"}, 32'(bus.arready), 32'd0);
    check({tag, "_bvalid"},  32'(bus.bvalid),  32'd0);
    check({tag, "_bresp"},   32'(bus.bresp),   32'd0);
    check({tag, "_rvalid"},  32'(bus.rvalid),  32'd0);
    check({tag, "_rdata"},   bus.rdata,        32'd0);
    check({tag, "_rresp"},   32'(bus.rresp),   32'd0);
  endtask

  // AW offered from cycle aw_dly, W from cycle w_dly; bready held low for b_dly cycles
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input int b_dly);
    int cyc;
    bit aw_done, w_done, hs_aw, hs_w;
    logic [2:0] exp_resp;
    exp_resp = model_resp(addr);
    cyc = 0; aw_done = 0; w_done = 0;
    bus.awaddr = addr;
    bus.awprot = 3'($urandom);
    bus.wdata  = data;
    bus.wstrb  = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      bus.awvalid = !aw_done && (cyc >= aw_dly);
      bus.wvalid  = !w_done  && (cyc >= w_dly);
      if (aw_done) check("awready_while_held", 32'(bus.awready), 32'd0);
      if (w_done)  check("wready_while_held",  32'(bus.wready),  32'd0);
      hs_aw = bus.awvalid && bus.awready;
      hs_w  = bus.wvalid  && bus.wready;
      tick();
      cyc++;
      aw_done = aw_done || hs_aw;
      w_done  = w_done  || hs_w;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    if (!(aw_done && w_done)) begin
      check("write_handshake_timeout", 32'd0, 32'd1);
      return;
    end
    check("bvalid_before_commit", 32'(bus.bvalid), 32'd0);
    tick();
    check("bvalid_after_commit", 32'(bus.bvalid), 32'd1);
    check("bresp", 32'(bus.bresp), 32'(exp_resp));
    for (int i = 0; i < b_dly; i++) begin
      tick();
      check("bvalid_hold",  32'(bus.bvalid),  32'd1);
      check("bresp_hold",   32'(bus.bresp),   32'(exp_resp));
      check("awready_hold", 32'(bus.awready), 32'd0);
      check("wready_hold",  32'(bus.wready),  32'd0);
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    check("bvalid_fall",     32'(bus.bvalid),  32'd0);
    check("awready_restore", 32'(bus.awready), 32'd1);
    check("wready_restore",  32'(bus.wready),  32'd1);
    model_write(addr, data, strb);
    $display("WR addr=0x%08h data=0x%08h strb=%b aw_dly=%0d w_dly=%0d b_dly=%0d bresp=%b",
             addr, data, strb, aw_dly, w_dly, b_dly, exp_resp);
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
    int cyc;
    bit done, hs;
    logic [31:0] exp_data;
    logic [2:0]  exp_resp;
    exp_data = model_read(addr);
    exp_resp = model_resp(addr);
    cyc = 0; done = 0;
    bus.araddr = addr;
    bus.arprot = 3'($urandom);
    while (!done && cyc < 40) begin
      bus.arvalid = (cyc >= ar_dly);
      hs = bus.arvalid && bus.arready;
      tick();
      cyc++;
      done = hs;
    end
    bus.arvalid = 1'b0;
    if (!done) begin
      check("read_handshake_timeout", 32'd0, 32'd1);
      return;
    end
    check("rvalid",       32'(bus.rvalid),  32'd1);
    check("rdata",        bus.rdata,        exp_data);
    check("rresp",        32'(bus.rresp),   32'(exp_resp));
    check("arready_busy", 32'(bus.arready), 32'd0);
    for (int i = 0; i < r_dly; i++) begin
      tick();
      check("rvalid_hold",  32'(bus.rvalid),  32'd1);
      check("rdata_hold",   bus.rdata,        exp_data);
      check("rresp_hold",   32'(bus.rresp),   32'(exp_resp));
      check("arready_hold", 32'(bus.arready), 32'd0);
    end
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    check("rvalid_fall",     32'(bus.rvalid),  32'd0);
    check("arready_restore", 32'(bus.arready), 32'd1);
    $display("RD addr=0x%08h data=0x%08h rresp=%b ar_dly=%0d r_dly=%0d",
             addr, exp_data, exp_resp, ar_dly, r_dly);
  endtask

  initial begin
    logic [31:0] old_val;
    logic [31:0] addr;
    int unsigned idx;

    bus.awvalid = 1'b0; bus.awaddr = '0; bus.awprot = '0;
    bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb  = '0;
    bus.bready  = 1'b0;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arprot = '0;
    bus.rready  = 1'b0;
    for (int r = 0; r < NR; r++) model[r] = 32'h0;

    // reset state
    arst_n = 1'b0;
    tick(); tick(); tick();
    outputs_zero("reset");
    arst_n = 1'b1;
    check("awready_before_first_edge", 32'(bus.awready), 32'd0);
    tick();
    check("awready_first_edge", 32'(bus.awready), 32'd1);
    check("wready_first_edge",  32'(bus.wready),  32'd1);
    check("arready_first_edge", 32'(bus.arready), 32'd1);
    $display("RST released");

    // basic write then read back
    do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(32'h4, 0, 0);

    // W two cycles ahead of AW
    do_write(32'hC, 32'h0BADF00D, 4'hF, 2, 0, 0);
    do_read(32'hC, 0, 0);
    // AW ahead of W
    do_write(32'h10, 32'h5A5AA5A5, 4'hF, 0, 3, 0);
    do_read(32'h10, 1, 0);

    // partial-strobe merge
    do_write(32'h8, 32'h11223344, 4'hF, 0, 0, 0);
    do_write(32'h8, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    do_read(32'h8, 0, 0);

    // out-of-range accesses; reg 0 must not be aliased
    do_write(32'h0, 32'hCAFE0000, 4'hF, 0, 0, 0);
    do_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_read(32'h40, 0, 0);
    do_read(32'h0, 0, 0);
    do_read(32'h4, 0, 0);
    do_write(32'h8000_0004, 32'h12345678, 4'hF, 1, 0, 0);
    do_read(32'h8000_0004, 0, 0);
    do_read(32'h4, 0, 0);

    // back-pressure on B and R
    do_write(32'h18, 32'h600DCAFE, 4'hF, 0, 0, 5);
    do_read(32'h18, 0, 5);
    do_write(32'h44, 32'h0, 4'hF, 0, 0, 5);
    do_read(32'h48, 0, 5);

    // read and write commit on the same edge to the same register
    old_val = model[5];
    bus.awaddr = 32'h14; bus.wdata = 32'h76543210; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = 32'h14; bus.arvalid = 1'b1;
    check("collide_arready", 32'(bus.arready), 32'd1);
    tick();
    bus.arvalid = 1'b0;
    check("collide_bvalid", 32'(bus.bvalid), 32'd1);
    check("collide_rvalid", 32'(bus.rvalid), 32'd1);
    check("collide_rdata_old", bus.rdata, old_val);
    bus.bready = 1'b1; bus.rready = 1'b1;
    tick();
    bus.bready = 1'b0; bus.rready = 1'b0;
    check("collide_bvalid_fall", 32'(bus.bvalid), 32'd0);
    check("collide_rvalid_fall", 32'(bus.rvalid), 32'd0);
    model_write(32'h14, 32'h76543210, 4'hF);
    $display("WR+RD collide addr=0x00000014 old=0x%08h new=0x76543210", old_val);
    do_read(32'h14, 0, 0);

    // randomized traffic
    for (int t = 0; t < 80; t++) begin
      idx  = $urandom_range(0, NR + 3);
      addr = (idx << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        do_write(addr, $urandom, 4'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        do_read(addr, $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

    // reset in the middle of a write
    bus.awaddr = 32'h20; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    arst_n = 1'b0;
    tick();
    outputs_zero("mid_reset");
    arst_n = 1'b1;
    tick();
    check("post_reset_awready", 32'(bus.awready), 32'd1);
    check("post_reset_wready",  32'(bus.wready),  32'd1);
    check("post_reset_bvalid",  32'(bus.bvalid),  32'd0);
    for (int r = 0; r < NR; r++) model[r] = 32'h0;
    $display("RST mid-write");
    for (int r = 0; r < NR; r++) begin
      do_read(32'(r * 4), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
